// File: rtl/dnnbp_pkg.sv
// dnnbp_pkg: shared fixed-point defaults for the backprop datapath blocks
package dnnbp_pkg;
  localparam int DWIDTH_DEF = 32;
  localparam int FRAC_DEF = 24;
  localparam logic signed [DWIDTH_DEF-1:0] ONE = DWIDTH_DEF'(1) <<< FRAC_DEF;
  localparam logic signed [DWIDTH_DEF-1:0] CLIP_DEF = ONE;
endpackage

// File: rtl/sat_clip.sv
// sat_clip: saturate a signed value to [-CLIP, +CLIP], flagging when it clipped
module sat_clip
  import dnnbp_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter logic signed [DWIDTH-1:0] CLIP = CLIP_DEF
) (
  input  logic signed [DWIDTH-1:0] i,
  output logic signed [DWIDTH-1:0] o,
  output logic                     o_sat
);
  logic hi, lo;
  always_comb begin
    hi = i > CLIP;
    lo = i < -CLIP;
    o = hi ? CLIP : lo ? -CLIP : i;
    o_sat = hi | lo;
  end
endmodule

// File: rtl/grad_fanout_3out.sv
// grad_fanout_3out: broadcast one delta to three independently handshaked branches.
// Define GRAD_CLIP_EN to saturate captured deltas to [-CLIP, +CLIP].
module grad_fanout_3out
  import dnnbp_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int CWIDTH = 16,
  parameter logic signed [DWIDTH-1:0] CLIP = DWIDTH'(1) <<< FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DWIDTH-1:0] i_delta,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic signed [DWIDTH-1:0] o_delta,
  output logic                     o_valid_a,
  output logic                     o_valid_b,
  output logic                     o_valid_c,
  input  logic                     i_ready_a,
  input  logic                     i_ready_b,
  input  logic                     i_ready_c,
  output logic                     o_busy,
  output logic [CWIDTH-1:0]        o_cnt,
  output logic                     o_clipped
);
  logic signed [DWIDTH-1:0] d_q, cap;
  logic [2:0] pend, rdy;
  logic [CWIDTH-1:0] cnt_q;
  logic clip_q, sat, acc, last;
`ifdef GRAD_CLIP_EN
  sat_clip #(.DWIDTH(DWIDTH), .CLIP(CLIP)) u_clip (.i(i_delta), .o(cap), .o_sat(sat));
`else
  logic unused_clip;
  assign cap = i_delta;
  assign sat = 1'b0;
  assign unused_clip = ^CLIP;
`endif
  // last: every still-pending branch completes this cycle
  always_comb begin
    rdy = {i_ready_c, i_ready_b, i_ready_a};
    o_ready = &(~pend | rdy);
    acc = i_valid & o_ready;
    last = (|pend) & ~|(pend & ~rdy);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      pend <= '0;
      cnt_q <= '0;
      clip_q <= 1'b0;
    end else begin
      if (acc) begin
        d_q <= cap;
        pend <= 3'b111;
        clip_q <= sat;
      end else begin
        pend <= pend & ~rdy;
      end
      if (last) cnt_q <= cnt_q + CWIDTH'(1);
    end
  end
  assign o_delta = d_q;
  assign {o_valid_c, o_valid_b, o_valid_a} = pend;
  assign o_busy = |pend;
  assign o_cnt = cnt_q;
  assign o_clipped = clip_q;
endmodule

// File: tb/tb_grad_fanout_3out.sv
// tb_grad_fanout_3out: vector table, corner sequences and randomized model check
module tb_grad_fanout_3out;
  localparam logic signed [31:0] CL = 32'sh0100_0000;
  logic clk = 1'b0;
  logic rst, i_valid, i_ready_a, i_ready_b, i_ready_c;
  logic o_ready, o_valid_a, o_valid_b, o_valid_c, o_busy, o_clipped;
  logic [31:0] i_delta, o_delta;
  logic [15:0] o_cnt;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  grad_fanout_3out dut (
    .clk(clk), .rst(rst), .i_delta(i_delta), .i_valid(i_valid), .o_ready(o_ready),
    .o_delta(o_delta), .o_valid_a(o_valid_a), .o_valid_b(o_valid_b), .o_valid_c(o_valid_c),
    .i_ready_a(i_ready_a), .i_ready_b(i_ready_b), .i_ready_c(i_ready_c),
    .o_busy(o_busy), .o_cnt(o_cnt), .o_clipped(o_clipped)
  );
  typedef struct {
    logic r; logic v; logic [31:0] d; logic [2:0] rd;
    logic [2:0] ev; logic [31:0] ed; logic er; logic [15:0] ec;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic [2:0] rd);
    rst = r; i_valid = v; i_delta = d; {i_ready_c, i_ready_b, i_ready_a} = rd;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] clipf(input logic signed [31:0] v);
`ifdef GRAD_CLIP_EN
    return v > CL ? CL : v < -CL ? -CL : v;
`else
    return v;
`endif
  endfunction
  function automatic logic clipflag(input logic signed [31:0] v);
`ifdef GRAD_CLIP_EN
    return (v > CL) || (v < -CL);
`else
    return 1'b0;
`endif
  endfunction
  logic [2:0] owed;
  logic [31:0] md, x;
  logic [15:0] mcnt;
  logic mclip, mrdy, r, v;
  logic [2:0] rd;
  logic [31:0] d;
  initial begin
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         3'b111, 3'b000, 32'h0,         1'b1, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0080_0000, 3'b111, 3'b000, 32'h0,         1'b1, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         3'b111, 3'b111, 32'h0080_0000, 1'b1, 16'd0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         3'b000, 3'b000, 32'h0080_0000, 1'b1, 16'd1};
    tbl[4]  = '{1'b0, 1'b1, 32'hFFC0_0000, 3'b000, 3'b000, 32'h0080_0000, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 1'b1, 32'h0000_1111, 3'b001, 3'b111, 32'hFFC0_0000, 1'b0, 16'd1};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_1111, 3'b000, 3'b110, 32'hFFC0_0000, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_1111, 3'b100, 3'b110, 32'hFFC0_0000, 1'b0, 16'd1};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_1111, 3'b000, 3'b010, 32'hFFC0_0000, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_1111, 3'b010, 3'b010, 32'hFFC0_0000, 1'b1, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         3'b001, 3'b111, 32'h0000_1111, 1'b0, 16'd2};
    tbl[11] = '{1'b1, 1'b1, 32'h0000_2222, 3'b000, 3'b110, 32'h0000_1111, 1'b0, 16'd2};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         3'b111, 3'b000, 32'h0,         1'b1, 16'd0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         3'b111, 3'b000, 32'h0,         1'b1, 16'd0};
    // reset with i_valid asserted must still leave the block idle
    drive(1'b1, 1'b1, 32'h1234_5678, 3'b111);
    tick;
    tick;
    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].v, tbl[k].d, tbl[k].rd);
      chk($sformatf("tbl%0d valid", k), {29'd0, o_valid_c, o_valid_b, o_valid_a}, {29'd0, tbl[k].ev});
      chk($sformatf("tbl%0d delta", k), o_delta, tbl[k].ed);
      chk($sformatf("tbl%0d ready", k), {31'd0, o_ready}, {31'd0, tbl[k].er});
      chk($sformatf("tbl%0d cnt", k), {16'd0, o_cnt}, {16'd0, tbl[k].ec});
      chk($sformatf("tbl%0d busy", k), {31'd0, o_busy}, {31'd0, |tbl[k].ev});
      tick;
    end
    // back-to-back stream of 10 with all consumers ready
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 32'h0010_0000 * k, 3'b111);
      chk($sformatf("stream%0d ready", k), {31'd0, o_ready}, 32'd1);
      tick;
      chk($sformatf("stream%0d delta", k), o_delta, 32'h0010_0000 * k);
    end
    drive(1'b0, 1'b0, 32'h0, 3'b111);
    tick;
    chk("stream cnt", {16'd0, o_cnt}, 32'd10);
    chk("stream idle", {29'd0, o_valid_c, o_valid_b, o_valid_a}, 32'd0);
    // branch B stalls for 20 cycles while the producer keeps offering new data
    drive(1'b0, 1'b1, 32'h0ABC_0000, 3'b111);
    tick;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, 32'h0000_0100 + k, 3'b101);
      chk($sformatf("hold%0d ready", k), {31'd0, o_ready}, 32'd0);
      chk($sformatf("hold%0d delta", k), o_delta, 32'h0ABC_0000);
      chk($sformatf("hold%0d vb", k), {31'd0, o_valid_b}, 32'd1);
      tick;
    end
    chk("hold va", {31'd0, o_valid_a}, 32'd0);
    chk("hold cnt", {16'd0, o_cnt}, 32'd10);
    drive(1'b0, 1'b0, 32'h0, 3'b010);
    tick;
    chk("hold release cnt", {16'd0, o_cnt}, 32'd11);
    // clip behaviour (saturating only when GRAD_CLIP_EN is defined)
    drive(1'b0, 1'b1, 32'h0300_0000, 3'b111);
    tick;
    chk("clip pos delta", o_delta, clipf(32'sh0300_0000));
    chk("clip pos flag", {31'd0, o_clipped}, {31'd0, clipflag(32'sh0300_0000)});
    drive(1'b0, 1'b1, 32'hFD00_0000, 3'b111);
    tick;
    chk("clip neg delta", o_delta, clipf(32'shFD00_0000));
    chk("clip neg flag", {31'd0, o_clipped}, {31'd0, clipflag(32'shFD00_0000)});
    drive(1'b0, 1'b1, 32'h0080_0000, 3'b111);
    tick;
    chk("clip half delta", o_delta, 32'h0080_0000);
    chk("clip half flag", {31'd0, o_clipped}, 32'd0);
    // randomized traffic against a delivery-bookkeeping model
    drive(1'b1, 1'b0, 32'h0, 3'b000);
    tick;
    owed = 3'b000; md = 32'h0; mcnt = 16'd0; mclip = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      x = $urandom;
      d = ($urandom_range(0, 1) != 0) ? x : {{6{x[31]}}, x[25:0]};
      rd = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      drive(r, v, d, rd);
      mrdy = 1'b1;
      for (int b = 0; b < 3; b++) if (owed[b] && !rd[b]) mrdy = 1'b0;
      chk("rnd valid", {29'd0, o_valid_c, o_valid_b, o_valid_a}, {29'd0, owed});
      chk("rnd delta", o_delta, md);
      chk("rnd ready", {31'd0, o_ready}, {31'd0, mrdy});
      chk("rnd cnt", {16'd0, o_cnt}, {16'd0, mcnt});
      chk("rnd clipped", {31'd0, o_clipped}, {31'd0, mclip});
      if (r) begin
        owed = 3'b000; md = 32'h0; mcnt = 16'd0; mclip = 1'b0;
      end else begin
        if (owed != 3'b000 && mrdy) mcnt = mcnt + 16'd1;
        if (v && mrdy) begin
          md = clipf(d); mclip = clipflag(d); owed = 3'b111;
        end else begin
          for (int b = 0; b < 3; b++) if (rd[b]) owed[b] = 1'b0;
        end
      end
      tick;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
